// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcodes, FSM states and
// the bit positions of the status flags.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOT = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_XOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_MUL = 3'b110,
    OP_DIV = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int FLAGS_W = 5;
  localparam int FLAG_Z  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 2;
  localparam int FLAG_V  = 3;
  localparam int FLAG_DZ = 4;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the operand muxes and the ALU; the master
// issues operations, the slave (the ALU) returns results and status.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic               start;
  op_t                op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_hi;
  logic [FLAGS_W-1:0] flags;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, result_hi, flags
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, result_hi, flags
  );
endinterface

// File: rtl/alu_seq_add_w.sv
// WIDTH-bit ripple-carry adder shared by every arithmetic path of the ALU.
module add_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  always_comb begin : ripple
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic/ADD/SUB complete on the accepting edge, unsigned
// MUL (shift-add) and DIV (restoring) iterate WIDTH cycles on one adder.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MSB   = WIDTH - 1;

  state_t             state;
  op_t                op_q;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   result_q, result_hi_q;
  logic [FLAGS_W-1:0] flags_q;

  logic [WIDTH-1:0]   b_q, acc, sh;
  logic [WIDTH-1:0]   add_a, add_b, add_s;
  logic               add_ci, add_co;
  logic [WIDTH-1:0]   one_res;
  logic [FLAGS_W-1:0] one_flags;
  logic [WIDTH-1:0]   acc_nx, sh_nx;
  logic               div_ok;
  logic [FLAGS_W-1:0] calc_flags;

  // SUB feeds ~b into the adder, so one rule covers both ADD and SUB overflow.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                      input logic s_msb);
    return (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

  add_w #(.WIDTH(WIDTH)) u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (add_ci),
    .s   (add_s),
    .cout(add_co)
  );

  // Adder steering: live bus operands in IDLE, iteration registers in CALC.
  always_comb begin
    add_a  = bus.a;
    add_b  = bus.b;
    add_ci = bus.cin;
    if (state == CALC) begin
      if (op_q == OP_MUL) begin
        add_a  = acc;
        add_b  = sh[0] ? b_q : '0;
        add_ci = 1'b0;
      end else begin
        add_a  = {acc[MSB-1:0], sh[MSB]};
        add_b  = ~b_q;
        add_ci = 1'b1;
      end
    end else if (bus.op == OP_SUB) begin
      add_b  = ~bus.b;
      add_ci = 1'b1;
    end
  end

  always_comb begin
    one_res   = '0;
    one_flags = '0;
    case (bus.op)
      OP_NOT:         one_res = ~bus.a;
      OP_AND:         one_res = bus.a & bus.b;
      OP_OR:          one_res = bus.a | bus.b;
      OP_XOR:         one_res = bus.a ^ bus.b;
      OP_ADD, OP_SUB: one_res = add_s;
      default:        one_res = '0;
    endcase
    one_flags[FLAG_Z] = (one_res == '0);
    one_flags[FLAG_N] = one_res[MSB];
    if (bus.op == OP_ADD || bus.op == OP_SUB) begin
      one_flags[FLAG_C] = add_co;
      one_flags[FLAG_V] = signed_ovf(bus.a[MSB], add_b[MSB], add_s[MSB]);
    end
  end

  // Remainder below b keeps the shifted trial within WIDTH+1 bits; acc MSB is the extra bit.
  assign div_ok = acc[MSB] | add_co;

  always_comb begin
    if (op_q == OP_MUL) begin
      acc_nx = {add_co, add_s[MSB:1]};
      sh_nx  = {add_s[0], sh[MSB:1]};
    end else begin
      acc_nx = div_ok ? add_s : {acc[MSB-1:0], sh[MSB]};
      sh_nx  = {sh[MSB-1:0], div_ok};
    end
  end

  always_comb begin
    calc_flags = '0;
    if (op_q == OP_MUL) begin
      calc_flags[FLAG_Z] = (acc_nx == '0) && (sh_nx == '0);
      calc_flags[FLAG_N] = acc_nx[MSB];
    end else begin
      calc_flags[FLAG_Z]  = (sh_nx == '0);
      calc_flags[FLAG_N]  = sh_nx[MSB];
      calc_flags[FLAG_DZ] = (b_q == '0);
    end
  end

  // Iteration datapath: sh holds multiplier/low product or dividend/quotient.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      b_q <= bus.b;
      acc <= '0;
      sh  <= bus.a;
    end else if (state == CALC) begin
      acc <= acc_nx;
      sh  <= sh_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= OP_NOT;
      cnt         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            busy_q <= 1'b1;
            if (bus.op == OP_MUL || bus.op == OP_DIV) begin
              cnt   <= CNT_W'(WIDTH);
              state <= CALC;
            end else begin
              result_q    <= one_res;
              result_hi_q <= '0;
              flags_q     <= one_flags;
              done_q      <= 1'b1;
              state       <= FIN;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result_q    <= sh_nx;
            result_hi_q <= acc_nx;
            flags_q     <= calc_flags;
            done_q      <= 1'b1;
            state       <= FIN;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=8 op set, latency, busy/ignore rules,
// mid-op reset, plus a WIDTH=16 instance for the parameter sweep.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   lat, bcnt, ndone;

  op_t        lops[4] = '{OP_NOT, OP_AND, OP_OR, OP_XOR};
  logic [7:0] lexp[4] = '{8'h0F, 8'h30, 8'hFC, 8'hCC};
  logic [4:0] lflg[4] = '{5'h00, 5'h00, 5'h02, 5'h02};

  alu_seq_if #(.WIDTH(8))  i8 ();
  alu_seq_if #(.WIDTH(16)) i16 ();

  alu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  alu_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w16, input logic go, input op_t o,
                       input logic [15:0] av, input logic [15:0] bv, input logic ci);
    if (w16) begin
      i16.start = go; i16.op = o; i16.a = av; i16.b = bv; i16.cin = ci;
    end else begin
      i8.start = go; i8.op = o; i8.a = av[7:0]; i8.b = bv[7:0]; i8.cin = ci;
    end
  endtask

  // Called one step after an edge; l is the cycle index at which done is seen.
  task automatic wait_done(input bit w16, output int l, output int bc);
    l  = 0;
    bc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (w16 ? i16.busy : i8.busy) bc++;
      if (w16 ? i16.done : i8.done) begin
        l = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input bit w16, input op_t o, input logic [15:0] av,
                     input logic [15:0] bv, input logic ci, output int l, output int bc);
    @(negedge clk);
    for (int k = 0; k < 50 && (w16 ? i16.busy : i8.busy); k++) @(negedge clk);
    drive(w16, 1'b1, o, av, bv, ci);
    @(posedge clk); #1;
    drive(w16, 1'b0, o, av, bv, ci);
    wait_done(w16, l, bc);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, OP_NOT, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, OP_NOT, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(i8.busy), 32'h0);
    chk("rst_done",  32'(i8.done), 32'h0);
    chk("rst_res",   32'(i8.result), 32'h0);
    chk("rst_hi",    32'(i8.result_hi), 32'h0);
    chk("rst_flags", 32'(i8.flags), 32'h0);
    rst_n = 1'b1;

    run(1'b0, OP_ADD, 16'hFF, 16'h01, 1'b0, lat, bcnt);
    chk("add_lat",   32'(lat), 32'd1);
    chk("add_busy",  32'(bcnt), 32'd1);
    chk("add_res",   32'(i8.result), 32'h00);
    chk("add_hi",    32'(i8.result_hi), 32'h00);
    chk("add_flags", 32'(i8.flags), 32'h05);
    @(posedge clk); #1;
    chk("add_busy_fall", 32'(i8.busy), 32'h0);
    chk("add_done_fall", 32'(i8.done), 32'h0);

    run(1'b0, OP_SUB, 16'h80, 16'h01, 1'b0, lat, bcnt);
    chk("sub1_res",   32'(i8.result), 32'h7F);
    chk("sub1_flags", 32'(i8.flags), 32'h0C);
    run(1'b0, OP_SUB, 16'h03, 16'h05, 1'b1, lat, bcnt);
    chk("sub2_res",   32'(i8.result), 32'hFE);
    chk("sub2_flags", 32'(i8.flags), 32'h02);
    run(1'b0, OP_ADD, 16'h7F, 16'h00, 1'b1, lat, bcnt);
    chk("addc_res",   32'(i8.result), 32'h80);
    chk("addc_flags", 32'(i8.flags), 32'h0A);

    for (int i = 0; i < 4; i++) begin
      run(1'b0, lops[i], 16'hF0, 16'h3C, 1'b1, lat, bcnt);
      chk($sformatf("logic%0d_res", i),   32'(i8.result), 32'(lexp[i]));
      chk($sformatf("logic%0d_hi", i),    32'(i8.result_hi), 32'h00);
      chk($sformatf("logic%0d_flags", i), 32'(i8.flags), 32'(lflg[i]));
    end

    run(1'b0, OP_MUL, 16'hFF, 16'hFF, 1'b0, lat, bcnt);
    chk("mul_lat",   32'(lat), 32'd9);
    chk("mul_busy",  32'(bcnt), 32'd9);
    chk("mul_res",   32'(i8.result), 32'h01);
    chk("mul_hi",    32'(i8.result_hi), 32'hFE);
    chk("mul_flags", 32'(i8.flags), 32'h02);
    @(posedge clk); #1;
    chk("mul_busy_fall", 32'(i8.busy), 32'h0);
    run(1'b0, OP_MUL, 16'h00, 16'h37, 1'b0, lat, bcnt);
    chk("mul0_res",   32'(i8.result), 32'h00);
    chk("mul0_flags", 32'(i8.flags), 32'h01);
    run(1'b0, OP_MUL, 16'h10, 16'h10, 1'b0, lat, bcnt);
    chk("mul256_hi",    32'(i8.result_hi), 32'h01);
    chk("mul256_flags", 32'(i8.flags), 32'h00);

    run(1'b0, OP_DIV, 16'h64, 16'h07, 1'b0, lat, bcnt);
    chk("div_lat",   32'(lat), 32'd9);
    chk("div_res",   32'(i8.result), 32'h0E);
    chk("div_hi",    32'(i8.result_hi), 32'h02);
    chk("div_flags", 32'(i8.flags), 32'h00);
    run(1'b0, OP_DIV, 16'h2A, 16'h00, 1'b0, lat, bcnt);
    chk("divz_lat",   32'(lat), 32'd9);
    chk("divz_res",   32'(i8.result), 32'hFF);
    chk("divz_hi",    32'(i8.result_hi), 32'h2A);
    chk("divz_flags", 32'(i8.flags), 32'h12);
    run(1'b0, OP_DIV, 16'h05, 16'h09, 1'b0, lat, bcnt);
    chk("divs_res",   32'(i8.result), 32'h00);
    chk("divs_hi",    32'(i8.result_hi), 32'h05);
    chk("divs_flags", 32'(i8.flags), 32'h01);

    // MUL 0C*0B with an ADD request injected while busy
    @(negedge clk);
    for (int k = 0; k < 50 && i8.busy; k++) @(negedge clk);
    drive(1'b0, 1'b1, OP_MUL, 16'h0C, 16'h0B, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_MUL, 16'h0C, 16'h0B, 1'b0);
    @(posedge clk); #1;
    chk("hold_hi", 32'(i8.result_hi), 32'h05);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_ADD, 16'h01, 16'h01, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_ADD, 16'h01, 16'h01, 1'b0);
    wait_done(1'b0, lat, bcnt);
    chk("ign_lat",   32'(lat + 3), 32'd9);
    chk("ign_res",   32'(i8.result), 32'h84);
    chk("ign_hi",    32'(i8.result_hi), 32'h00);
    chk("ign_flags", 32'(i8.flags), 32'h00);
    drive(1'b0, 1'b1, OP_ADD, 16'h01, 16'h01, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_ADD, 16'h01, 16'h01, 1'b0);
    chk("donecyc_busy", 32'(i8.busy), 32'h0);
    chk("donecyc_res",  32'(i8.result), 32'h84);

    // Reset asserted in cycle 5 of a MUL
    @(negedge clk);
    drive(1'b0, 1'b1, OP_MUL, 16'hFF, 16'hFF, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_MUL, 16'hFF, 16'hFF, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(i8.busy), 32'h0);
    chk("abort_done", 32'(i8.done), 32'h0);
    chk("abort_res",  32'(i8.result), 32'h0);
    chk("abort_hi",   32'(i8.result_hi), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (i8.done) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);
    run(1'b0, OP_ADD, 16'h01, 16'h01, 1'b0, lat, bcnt);
    chk("post_lat", 32'(lat), 32'd1);
    chk("post_res", 32'(i8.result), 32'h02);

    run(1'b1, OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, lat, bcnt);
    chk("w16_mul_lat", 32'(lat), 32'd17);
    chk("w16_mul_res", 32'(i16.result), 32'h0001);
    chk("w16_mul_hi",  32'(i16.result_hi), 32'hFFFE);
    run(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b0, lat, bcnt);
    chk("w16_add_res",   32'(i16.result), 32'h8000);
    chk("w16_add_flags", 32'(i16.flags), 32'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
